// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S serial receiver producing per-frame stereo PCM words
//
// Oversamples SCLK/LRCK/SDATA in the clk_74b domain, captures the first DW
// bits (MSB first) of each slot, and commits a left+right pair once the right
// slot of a frame ends cleanly. Malformed slots raise a one-cycle frame_err.
//
// Ports:
//   clk_74b      - system clock (only clock)
//   reset_n      - synchronous active-low reset
//   i2s_sclk     - serial bit clock (asynchronous)
//   i2s_lrck     - word select, 0 = left, 1 = right (asynchronous)
//   i2s_sdata    - serial data (asynchronous)
//   audio_l      - last committed left sample
//   audio_r      - last committed right sample
//   sample_valid - one-cycle pulse when audio_l/audio_r update
//   frame_err    - one-cycle pulse on a short or overlong slot
module i2s_receiver #(
  parameter int DW        = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic          clk_74b,
  input  logic          reset_n,
  input  logic          i2s_sclk,
  input  logic          i2s_lrck,
  input  logic          i2s_sdata,
  output logic [DW-1:0] audio_l,
  output logic [DW-1:0] audio_r,
  output logic          sample_valid,
  output logic          frame_err
);

  localparam int CW = $clog2(SLOT_BITS + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SHIFT, ST_PAD} state_t;

  state_t        r_state, w_state_nx;
  logic          r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic          r_lr_s1, r_lr_s2, r_lr_prev;
  logic          r_sd_s1, r_sd_s2;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic          r_chan, w_chan_nx;
  logic [DW-1:0] r_shift, w_shift_nx, w_shift_in;
  logic [DW-1:0] r_hold_l, w_hold_l_nx;
  logic [DW-1:0] r_hold_r, w_hold_r_nx;
  logic          r_left_ok, w_left_ok_nx;
  logic [DW-1:0] r_audio_l, r_audio_r;
  logic          r_valid, r_err;
  logic          w_commit, w_err;
  logic          w_rise, w_lr, w_edge;

  assign w_rise     = r_sclk_s2 & ~r_sclk_d;
  assign w_lr       = r_lr_s2;
  assign w_edge     = w_lr ^ r_lr_prev;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_shift_in = {r_shift[DW-2:0], r_sd_s2};

  assign audio_l      = r_audio_l;
  assign audio_r      = r_audio_r;
  assign sample_valid = r_valid;
  assign frame_err    = r_err;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_chan_nx    = r_chan;
    w_shift_nx   = r_shift;
    w_hold_l_nx  = r_hold_l;
    w_hold_r_nx  = r_hold_r;
    w_left_ok_nx = r_left_ok;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    if (w_rise) begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nx = '0;
          if (w_edge) begin
            w_state_nx   = ST_SKIP;
            w_chan_nx    = w_lr;
            w_left_ok_nx = 1'b0;
          end
        end
        // The rise that reveals the LRCK change carries the delay bit (the
        // previous slot's LSB), so the first rise seen in SKIP is the MSB.
        ST_SKIP, ST_SHIFT: begin
          if (w_edge) begin
            w_err        = 1'b1;
            w_left_ok_nx = 1'b0;
            w_state_nx   = ST_SKIP;
            w_cnt_nx     = '0;
            w_chan_nx    = w_lr;
          end else begin
            w_shift_nx = w_shift_in;
            w_cnt_nx   = w_cnt_inc;
            if (w_cnt_inc == CW'(DW)) begin
              w_state_nx = ST_PAD;
              if (r_chan) begin
                w_hold_r_nx = w_shift_in;
              end else begin
                w_hold_l_nx  = w_shift_in;
                w_left_ok_nx = 1'b1;
              end
            end else begin
              w_state_nx = ST_SHIFT;
            end
          end
        end
        ST_PAD: begin
          if (w_edge) begin
            // A completed right slot commits only if its left partner landed.
            w_commit   = r_chan & r_left_ok;
            if (!w_lr) w_left_ok_nx = 1'b0;
            w_state_nx = ST_SKIP;
            w_cnt_nx   = '0;
            w_chan_nx  = w_lr;
          end else if (w_cnt_inc == CW'(SLOT_BITS + 1)) begin
            w_err        = 1'b1;
            w_left_ok_nx = 1'b0;
            w_state_nx   = ST_IDLE;
            w_cnt_nx     = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_74b) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_prev <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
      r_cnt     <= '0;
      r_chan    <= 1'b0;
      r_shift   <= '0;
      r_hold_l  <= '0;
      r_hold_r  <= '0;
      r_left_ok <= 1'b0;
      r_audio_l <= '0;
      r_audio_r <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sclk_s1 <= i2s_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_lr_s1   <= i2s_lrck;
      r_lr_s2   <= r_lr_s1;
      r_sd_s1   <= i2s_sdata;
      r_sd_s2   <= r_sd_s1;
      if (w_rise) r_lr_prev <= w_lr;
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_chan    <= w_chan_nx;
      r_shift   <= w_shift_nx;
      r_hold_l  <= w_hold_l_nx;
      r_hold_r  <= w_hold_r_nx;
      r_left_ok <= w_left_ok_nx;
      r_valid   <= w_commit;
      r_err     <= w_err;
      if (w_commit) begin
        r_audio_l <= r_hold_l;
        r_audio_r <= r_hold_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - self-checking bench for i2s_receiver
`timescale 1ns/10ps
module tb_i2s_receiver;

  localparam int DW = 16;
  localparam int SB = 32;
  localparam realtime HALF = 121.3;

  logic          clk_74b   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          i2s_sclk  = 1'b0;
  logic          i2s_lrck  = 1'b0;
  logic          i2s_sdata = 1'b0;
  logic [DW-1:0] audio_l, audio_r;
  logic          sample_valid, frame_err;

  i2s_receiver #(.DW(DW), .SLOT_BITS(SB)) dut (
    .clk_74b     (clk_74b),
    .reset_n     (reset_n),
    .i2s_sclk    (i2s_sclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdata   (i2s_sdata),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .sample_valid(sample_valid),
    .frame_err   (frame_err)
  );

  always #5 clk_74b = ~clk_74b;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int edge_mark = 0;
  int period_idx = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int err_period = -1;
  int lat;
  logic [2*DW-1:0] sb_q[$];
  logic [2*DW-1:0] exp_v;
  logic [DW-1:0]   prev_l = '0, prev_r = '0;

  // slot-level protocol model
  logic          m_prev_lr = 1'b0;
  logic          m_left_ok = 1'b0;
  logic [DW-1:0] m_lval = '0;
  int            m_err_exp = 0;
  logic          last_bit = 1'b0;
  bit            flushed = 1'b0;
  bit            flush_counted = 1'b0;

  always @(posedge clk_74b) edge_cnt <= edge_cnt + 1;

  always @(negedge clk_74b) begin
    if (reset_n !== 1'b1) begin
      prev_l = audio_l;
      prev_r = audio_r;
    end else begin
      if (sample_valid === 1'b1 || frame_err === 1'b1) begin
        n_cmp++;
        if (sample_valid === 1'b1 && frame_err === 1'b1) begin
          n_bad++;
          $display("FAIL pulse_overlap got valid=1 err=1 need at most one");
        end
      end
      if (frame_err === 1'b1) begin
        err_cnt++;
        err_period = period_idx;
      end
      if (sample_valid === 1'b1) begin
        valid_cnt++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid got l=%h r=%h need no pulse", audio_l, audio_r);
        end else begin
          exp_v = sb_q.pop_front();
          if ({audio_l, audio_r} !== exp_v) begin
            n_bad++;
            $display("FAIL commit_value got l=%h r=%h need l=%h r=%h",
                     audio_l, audio_r, exp_v[2*DW-1:DW], exp_v[DW-1:0]);
          end
        end
        n_cmp++;
        lat = edge_cnt - edge_mark;
        if (lat < 3 || lat > 4) begin
          n_bad++;
          $display("FAIL valid_latency got %0d cycles need 3..4", lat);
        end
      end else begin
        n_cmp++;
        if (audio_l !== prev_l || audio_r !== prev_r) begin
          n_bad++;
          $display("FAIL output_hold got l=%h r=%h need l=%h r=%h", audio_l, audio_r, prev_l, prev_r);
        end
      end
      prev_l = audio_l;
      prev_r = audio_r;
    end
  end

  task automatic drive_period(input logic lr, input logic d, input int j);
    period_idx = j;
    i2s_sclk   = 1'b0;
    i2s_lrck   = lr;
    i2s_sdata  = d;
    #(HALF);
    i2s_sclk = 1'b1;
    if (j == 0 && lr == 1'b0) edge_mark = edge_cnt;
    #(HALF);
  endtask

  // Sends n SCLK periods of one slot; period 0 carries the previous LSB.
  task automatic send_slot(input logic lr, input logic [31:0] w, input int n, input bit abort);
    int   j0;
    bit   counted;
    logic d;
    if (flushed) begin
      j0 = 1;
      counted = flush_counted;
      flushed = 1'b0;
    end else begin
      j0 = 0;
      counted = (lr != m_prev_lr);
    end
    for (int j = j0; j < n; j++) begin
      if (j == 0)       d = last_bit;
      else if (j <= 32) d = w[32-j];
      else              d = 1'($urandom);
      drive_period(lr, d, j);
    end
    m_prev_lr = lr;
    last_bit = (n <= 32) ? w[32-n] : 1'($urandom);
    if (!abort) begin
      if (!counted) begin
        m_left_ok = 1'b0;
      end else if (n < DW + 1 || n > SB + 1) begin
        m_err_exp++;
        m_left_ok = 1'b0;
      end else if (lr == 1'b0) begin
        m_left_ok = 1'b1;
        m_lval    = w[31:16];
      end else begin
        if (m_left_ok) sb_q.push_back({m_lval, w[31:16]});
        m_left_ok = 1'b0;
      end
    end
  endtask

  // Opens the next left slot so the pending right->left commit happens.
  task automatic flush();
    flush_counted = (m_prev_lr != 1'b0);
    drive_period(1'b0, last_bit, 0);
    flushed   = 1'b1;
    m_prev_lr = 1'b0;
  endtask

  task automatic test_reset();
    int v0;
    reset_n = 1'b0;
    repeat (4) begin
      @(posedge clk_74b);
      #2;
      i2s_sclk  = 1'($urandom);
      i2s_lrck  = 1'($urandom);
      i2s_sdata = 1'($urandom);
    end
    @(negedge clk_74b);
    n_cmp++; if (audio_l !== 16'h0) begin n_bad++; $display("FAIL reset_audio_l got %h need 0000", audio_l); end
    n_cmp++; if (audio_r !== 16'h0) begin n_bad++; $display("FAIL reset_audio_r got %h need 0000", audio_r); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b need 0", sample_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b need 0", frame_err); end
    i2s_sclk = 1'b0; i2s_lrck = 1'b0; i2s_sdata = 1'b0;
    #1 reset_n = 1'b1;
    #0.05;
    m_prev_lr = 1'b0; m_left_ok = 1'b0; last_bit = 1'b0; flushed = 1'b0;
    v0 = valid_cnt;
    send_slot(1'b0, $urandom, 32, 1'b0);
    send_slot(1'b1, $urandom, 32, 1'b0);
    flush();
    n_cmp++; if (valid_cnt - v0 != 0) begin n_bad++; $display("FAIL post_reset_valid got %0d need 0", valid_cnt - v0); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL post_reset_err got %0d need 0", err_cnt); end
  endtask

  task automatic test_nominal();
    int v0;
    v0 = valid_cnt;
    repeat (2) begin
      send_slot(1'b0, 32'h1234_0000, 32, 1'b0);
      send_slot(1'b1, 32'hABCD_0000, 32, 1'b0);
    end
    flush();
    n_cmp++; if (valid_cnt - v0 != 2) begin n_bad++; $display("FAIL nominal_count got %0d need 2", valid_cnt - v0); end
    n_cmp++; if (audio_l !== 16'h1234) begin n_bad++; $display("FAIL nominal_l got %h need 1234", audio_l); end
    n_cmp++; if (audio_r !== 16'hABCD) begin n_bad++; $display("FAIL nominal_r got %h need abcd", audio_r); end
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL nominal_pending got %0d need 0", sb_q.size()); end
  endtask

  task automatic test_extremes();
    send_slot(1'b0, 32'h8000_FFFF, 32, 1'b0);
    send_slot(1'b1, 32'h7FFF_A5A5, 32, 1'b0);
    flush();
    n_cmp++; if (audio_l !== 16'h8000) begin n_bad++; $display("FAIL extreme_l got %h need 8000", audio_l); end
    n_cmp++; if (audio_r !== 16'h7FFF) begin n_bad++; $display("FAIL extreme_r got %h need 7fff", audio_r); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    for (int k = 0; k < 3; k++) begin
      send_slot(1'b0, $urandom, 32, 1'b0);
      send_slot(1'b1, $urandom, 32, 1'b0);
    end
    flush();
    n_cmp++; if (valid_cnt - v0 != 3) begin n_bad++; $display("FAIL b2b_count got %0d need 3", valid_cnt - v0); end
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL b2b_pending got %0d need 0", sb_q.size()); end
  endtask

  task automatic test_short_slot();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_slot(1'b0, 32'h1357_0000, 32, 1'b0);
    send_slot(1'b1, 32'h2468_FFFF, 11, 1'b0);
    send_slot(1'b0, 32'h4444_0000, 32, 1'b0);
    send_slot(1'b1, 32'h5555_0000, 32, 1'b0);
    flush();
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL short_err got %0d need 1", err_cnt - e0); end
    n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("FAIL short_valid got %0d need 1", valid_cnt - v0); end
    n_cmp++; if (audio_l !== 16'h4444 || audio_r !== 16'h5555) begin
      n_bad++; $display("FAIL short_recover got l=%h r=%h need l=4444 r=5555", audio_l, audio_r);
    end
  endtask

  task automatic test_stall();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_slot(1'b0, 32'h0101_0000, 32, 1'b0);
    send_slot(1'b1, 32'h0202_0000, 40, 1'b0);
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL stall_err got %0d need 1", err_cnt - e0); end
    n_cmp++; if (err_period != 33) begin n_bad++; $display("FAIL stall_err_pos got %0d need 33", err_period); end
    send_slot(1'b0, 32'h0303_0000, 32, 1'b0);
    send_slot(1'b1, 32'h0404_0000, 32, 1'b0);
    flush();
    n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("FAIL stall_valid got %0d need 1", valid_cnt - v0); end
    n_cmp++; if (audio_l !== 16'h0303 || audio_r !== 16'h0404) begin
      n_bad++; $display("FAIL stall_recover got l=%h r=%h need l=0303 r=0404", audio_l, audio_r);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    send_slot(1'b0, 32'h7777_0000, 8, 1'b1);
    @(negedge clk_74b);
    #1 reset_n = 1'b0;
    @(negedge clk_74b);
    n_cmp++; if (audio_l !== 16'h0 || audio_r !== 16'h0) begin
      n_bad++; $display("FAIL midreset_out got l=%h r=%h need 0000", audio_l, audio_r);
    end
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got %b need 0", sample_valid); end
    @(negedge clk_74b);
    #1 reset_n = 1'b1;
    #0.05;
    m_prev_lr = 1'b0; m_left_ok = 1'b0; flushed = 1'b0;
    v0 = valid_cnt;
    send_slot(1'b0, $urandom, 24, 1'b0);
    send_slot(1'b1, 32'h1111_0000, 32, 1'b0);
    send_slot(1'b0, 32'h6789_0000, 32, 1'b0);
    send_slot(1'b1, 32'h9876_0000, 32, 1'b0);
    flush();
    n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("FAIL midreset_valid_cnt got %0d need 1", valid_cnt - v0); end
    n_cmp++; if (audio_l !== 16'h6789 || audio_r !== 16'h9876) begin
      n_bad++; $display("FAIL midreset_recover got l=%h r=%h need l=6789 r=9876", audio_l, audio_r);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_back_to_back();
    test_short_slot();
    test_stall();
    test_reset_mid();
    n_cmp++;
    if (err_cnt != m_err_exp) begin
      n_bad++; $display("FAIL total_err got %0d need %0d", err_cnt, m_err_exp);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL final_pending got %0d need 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
